// File: rtl/prefetch_ctrl_if.sv
// Bus bundle between the prefetch controller, instruction memory and realign buffer.
// The master modport is the controller's view; slave is the memory/buffer side.
interface prefetch_ctrl_if #(
  parameter int RISCV_ADDR_WIDTH = 32,
  parameter int RISCV_WORD_WIDTH = 32
) ();

  // instruction memory side
  logic                        imem_req_o;
  logic [RISCV_ADDR_WIDTH-1:0] imem_addr_o;
  logic                        imem_gnt_i;
  logic                        imem_rvalid_i;
  logic [RISCV_WORD_WIDTH-1:0] imem_rdata_i;

  // realign buffer side
  logic                        buf_clear_o;
  logic                        buf_read_offset_o;
  logic                        buf_write_en_o;
  logic [RISCV_WORD_WIDTH-1:0] buf_instr_o;
  logic [RISCV_ADDR_WIDTH-1:0] buf_addr_o;
  logic                        buf_full_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output buf_clear_o, buf_read_offset_o, buf_write_en_o, buf_instr_o, buf_addr_o,
    input  buf_full_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  buf_clear_o, buf_read_offset_o, buf_write_en_o, buf_instr_o, buf_addr_o,
    output buf_full_i
  );

endinterface

// File: rtl/prefetch_ctrl.sv
// Instruction prefetch controller: issues word-aligned fetches, tracks in-flight
// responses, drops stale ones after a redirect and queues returned words in a
// small FIFO so that nothing granted is lost while the realign buffer is full.
module prefetch_ctrl #(
  parameter int DEPTH            = 2,
  parameter int RISCV_ADDR_WIDTH = 32,
  parameter int RISCV_WORD_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fetch_enable_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] boot_addr_i,
  input  logic                        redirect_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] redirect_addr_i,
  prefetch_ctrl_if.master             bus,
  output logic                        busy_o
);

  localparam int AW     = RISCV_ADDR_WIDTH;
  localparam int WW     = RISCV_WORD_WIDTH;
  localparam int PTR_W  = (DEPTH > 2) ? 2 : 1;
  localparam int CNT_W  = 3;
  // discard only grows by redirects racing a slow memory; 8 bits is ample headroom
  localparam int DISC_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     fetch_addr_q, fetch_addr_d;
  logic              req_q, req_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              stale_q, stale_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [DISC_W-1:0] disc_q, disc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     resp_addr_q, resp_addr_d;
  logic [WW-1:0]     mem_data_q [DEPTH];
  logic [WW-1:0]     mem_data_d [DEPTH];
  logic [AW-1:0]     mem_addr_q [DEPTH];
  logic [AW-1:0]     mem_addr_d [DEPTH];
  logic              busy_q, busy_d;

  logic              start_s, redir_s, grant_s, rvalid_s, push_s, pop_s, clear_s;
  logic [3:0]        credit_sum_s;
  logic [AW-1:0]     boot_word_s, redir_word_s;
  logic              unused_s;

  // bit 0 of both addresses carries no meaning (halfword granularity)
  assign unused_s = ^{boot_addr_i[0], redirect_addr_i[0]};

  // FIFO pointer advance with wrap for non-power-of-two depths
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + 1'b1;
  endfunction

  // decode of this cycle's events; a redirect together with start overrides the boot address
  always_comb begin
    boot_word_s  = {boot_addr_i[AW-1:2], 2'b00};
    redir_word_s = {redirect_addr_i[AW-1:2], 2'b00};
    start_s      = (state_q == S_IDLE) && fetch_enable_i;
    redir_s      = redirect_i && ((state_q != S_IDLE) || fetch_enable_i);
    clear_s      = start_s || redir_s;
    grant_s      = req_q && bus.imem_gnt_i;
    rvalid_s     = bus.imem_rvalid_i;
    push_s       = rvalid_s && !redir_s && (disc_q == {DISC_W{1'b0}});
    pop_s        = (cnt_q != {CNT_W{1'b0}}) && !bus.buf_full_i && !clear_s;
  end

  // buffer-facing outputs are combinational so clear/offset land in the redirect cycle
  always_comb begin
    bus.buf_clear_o       = clear_s;
    bus.buf_write_en_o    = pop_s;
    bus.buf_instr_o       = mem_data_q[rd_ptr_q];
    bus.buf_addr_o        = mem_addr_q[rd_ptr_q];
    if (redir_s) begin
      bus.buf_read_offset_o = redirect_addr_i[1];
    end else if (start_s) begin
      bus.buf_read_offset_o = boot_addr_i[1];
    end else begin
      bus.buf_read_offset_o = 1'b0;
    end
  end

  // run-state sequencing: IDLE leaves once, RUN/HALT follow fetch_enable_i
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = fetch_enable_i ? S_RUN : S_IDLE;
      S_RUN:   state_d = fetch_enable_i ? S_RUN : S_HALT;
      S_HALT:  state_d = fetch_enable_i ? S_RUN : S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // in-flight bookkeeping; a redirect turns every live response into one to discard
  always_comb begin
    out_d   = out_q;
    disc_d  = disc_q;
    stale_d = stale_q;
    if (redir_s) begin
      disc_d  = disc_q + DISC_W'(out_q) + DISC_W'(grant_s) - DISC_W'(rvalid_s);
      out_d   = {CNT_W{1'b0}};
      stale_d = req_q && !bus.imem_gnt_i;
    end else begin
      disc_d  = disc_q + DISC_W'(grant_s && stale_q)
                       - DISC_W'(rvalid_s && (disc_q != {DISC_W{1'b0}}));
      out_d   = out_q + CNT_W'(grant_s && !stale_q)
                      - CNT_W'(rvalid_s && (disc_q == {DISC_W{1'b0}}));
      stale_d = stale_q && !grant_s;
    end
  end

  // response FIFO; resp_addr tracks the word address of the next live response
  always_comb begin
    mem_data_d  = mem_data_q;
    mem_addr_d  = mem_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    resp_addr_d = resp_addr_q;
    if (clear_s) begin
      wr_ptr_d    = {PTR_W{1'b0}};
      rd_ptr_d    = {PTR_W{1'b0}};
      cnt_d       = {CNT_W{1'b0}};
      resp_addr_d = redir_s ? redir_word_s : boot_word_s;
    end else begin
      if (push_s) begin
        mem_data_d[wr_ptr_q] = bus.imem_rdata_i;
        mem_addr_d[wr_ptr_q] = resp_addr_q;
        wr_ptr_d             = ptr_inc(wr_ptr_q);
        resp_addr_d          = resp_addr_q + AW'(32'd4);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      cnt_d = cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // fetch address and request issue; a held request keeps its address across redirects
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    req_d        = 1'b0;
    addr_d       = addr_q;
    credit_sum_s = 4'(out_d) + 4'(cnt_d);
    if (redir_s) begin
      fetch_addr_d = redir_word_s;
    end else if (start_s) begin
      fetch_addr_d = boot_word_s;
    end else if (grant_s && !stale_q) begin
      fetch_addr_d = fetch_addr_q + AW'(32'd4);
    end else begin
      fetch_addr_d = fetch_addr_q;
    end
    if (req_q && !bus.imem_gnt_i) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else if ((state_d == S_RUN) && (credit_sum_s < 4'(DEPTH))) begin
      req_d  = 1'b1;
      addr_d = fetch_addr_d;
    end else begin
      req_d  = 1'b0;
      addr_d = addr_q;
    end
    busy_d = req_d || stale_d || (out_d != {CNT_W{1'b0}}) ||
             (disc_d != {DISC_W{1'b0}}) || (cnt_d != {CNT_W{1'b0}});
  end

  assign bus.imem_req_o  = req_q;
  assign bus.imem_addr_o = addr_q;
  assign busy_o          = busy_q;

  // state registers, all cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= {AW{1'b0}};
      req_q        <= 1'b0;
      addr_q       <= {AW{1'b0}};
      stale_q      <= 1'b0;
      out_q        <= {CNT_W{1'b0}};
      disc_q       <= {DISC_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      resp_addr_q  <= {AW{1'b0}};
      busy_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= {WW{1'b0}};
        mem_addr_q[i] <= {AW{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      stale_q      <= stale_d;
      out_q        <= out_d;
      disc_q       <= disc_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      resp_addr_q  <= resp_addr_d;
      busy_q       <= busy_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= mem_data_d[i];
        mem_addr_q[i] <= mem_addr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_prefetch_ctrl.sv
// Bench for prefetch_ctrl: directed scenarios plus a randomized run, all checked
// every cycle against a queue-based model of requests, in-flight responses and the FIFO.
module tb_prefetch_ctrl;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_enable_i;
  logic [31:0] boot_addr_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        busy_o;

  prefetch_ctrl_if #(.RISCV_ADDR_WIDTH(32), .RISCV_WORD_WIDTH(32)) bus ();

  prefetch_ctrl #(.DEPTH(DEPTH), .RISCV_ADDR_WIDTH(32), .RISCV_WORD_WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_enable_i  (fetch_enable_i),
    .boot_addr_i     (boot_addr_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .bus             (bus),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit live; } fl_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } fe_t;

  // model: 0 idle, 1 run, 2 halt
  int          m_state;
  bit          m_req, m_stale;
  logic [31:0] m_addr, m_fetch;
  fl_t         m_infl[$];
  fe_t         m_fifo[$];

  logic [31:0] mem_q[$];
  logic [31:0] gnt_log[$];
  logic [31:0] wr_log[$];
  int          wr_cyc[$];
  logic [31:0] clr_log[$];
  logic [31:0] s_addr;
  logic        s_busy;
  int          cyc;
  int          n_chk;
  int          n_fail;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int k);
    return (q.size() > k) ? q[k] : 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_req = 1'b0; m_stale = 1'b0; m_addr = 32'h0; m_fetch = 32'h0;
    m_infl.delete(); m_fifo.delete(); mem_q.delete();
    gnt_log.delete(); wr_log.delete(); wr_cyc.delete(); clr_log.delete();
  endtask

  // asynchronous reset applied mid-cycle, outputs checked while it is held
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    fetch_enable_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = 32'h0;
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = 32'h0;
    bus.buf_full_i = 1'b0;
    #1;
    chk("rst_req",    32'(bus.imem_req_o), 32'd0);
    chk("rst_addr",   bus.imem_addr_o, 32'h0);
    chk("rst_wen",    32'(bus.buf_write_en_o), 32'd0);
    chk("rst_clear",  32'(bus.buf_clear_o), 32'd0);
    chk("rst_offset", 32'(bus.buf_read_offset_o), 32'd0);
    chk("rst_busy",   32'(busy_o), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one clock: drive inputs, compare all outputs with the model, then advance both
  task automatic cycle(input bit fe, input bit rd, input logic [31:0] ra,
                       input bit gnt, input bit full, input int rv_pct);
    bit          start, redir, exp_clear, exp_off, exp_wen, granted, rv, exp_busy, s_req;
    int          live;
    fl_t         f;
    fe_t         e;
    @(negedge clk);
    fetch_enable_i = fe; redirect_i = rd; redirect_addr_i = ra;
    bus.imem_gnt_i = gnt; bus.buf_full_i = full;
    rv = (mem_q.size() != 0) && ($urandom_range(99) < rv_pct);
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rv ? data_of(mem_q[0]) : 32'h0;
    #1;
    start     = (m_state == 0) && fe;
    redir     = rd && ((m_state != 0) || fe);
    exp_clear = start || redir;
    exp_off   = redir ? ra[1] : (start ? boot_addr_i[1] : 1'b0);
    exp_wen   = (m_fifo.size() != 0) && !full && !exp_clear;
    exp_busy  = m_req || (m_infl.size() != 0) || (m_fifo.size() != 0);
    chk("imem_req", 32'(bus.imem_req_o), 32'(m_req));
    if (m_req) chk("imem_addr", bus.imem_addr_o, m_addr);
    chk("buf_clear", 32'(bus.buf_clear_o), 32'(exp_clear));
    if (exp_clear) chk("buf_offset", 32'(bus.buf_read_offset_o), 32'(exp_off));
    chk("buf_wen", 32'(bus.buf_write_en_o), 32'(exp_wen));
    if (exp_wen) begin
      chk("buf_instr", bus.buf_instr_o, m_fifo[0].data);
      chk("buf_addr",  bus.buf_addr_o,  m_fifo[0].addr);
    end
    chk("busy", 32'(busy_o), 32'(exp_busy));
    s_req  = bus.imem_req_o;
    s_addr = bus.imem_addr_o;
    s_busy = busy_o;
    if (bus.buf_clear_o) clr_log.push_back(32'(bus.buf_read_offset_o));
    if (bus.buf_write_en_o) begin
      wr_log.push_back(bus.buf_addr_o);
      wr_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    // memory: in-order responses, at least one cycle after the grant
    if (rv) void'(mem_q.pop_front());
    if (s_req && gnt) begin
      mem_q.push_back(s_addr);
      gnt_log.push_back(s_addr);
    end
    // model update
    granted = m_req && gnt;
    if (rv && (m_infl.size() != 0)) begin
      f = m_infl.pop_front();
      if (f.live && !redir) begin
        e.addr = f.addr; e.data = data_of(f.addr);
        m_fifo.push_back(e);
      end
    end
    if (exp_wen) void'(m_fifo.pop_front());
    if (granted) begin
      f.addr = m_addr; f.live = !m_stale && !redir;
      m_infl.push_back(f);
    end
    if (redir) begin
      m_fifo.delete();
      foreach (m_infl[i]) m_infl[i].live = 1'b0;
    end
    if (redir)                      m_fetch = {ra[31:2], 2'b00};
    else if (start)                 m_fetch = {boot_addr_i[31:2], 2'b00};
    else if (granted && !m_stale)   m_fetch = m_fetch + 32'd4;
    m_stale = redir ? (m_req && !gnt) : (m_stale && !granted);
    case (m_state)
      0: if (fe) m_state = 1;
      1: if (!fe) m_state = 2;
      2: if (fe) m_state = 1;
      default: m_state = 0;
    endcase
    live = 0;
    foreach (m_infl[i]) if (m_infl[i].live) live++;
    if (m_req && !gnt) begin
      m_req = 1'b1;
    end else if ((m_state == 1) && (live + m_fifo.size() < DEPTH)) begin
      m_req  = 1'b1;
      m_addr = m_fetch;
    end else begin
      m_req = 1'b0;
    end
  endtask

  initial begin
    bit fe_r;
    n_chk = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0;
    boot_addr_i = 32'h100;
    model_reset();

    // sequential fetch from 0x100 with a fast memory
    do_reset();
    boot_addr_i = 32'h100;
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 100);
    chk("seq_gnt0", q_at(gnt_log, 0), 32'h100);
    chk("seq_gnt1", q_at(gnt_log, 1), 32'h104);
    chk("seq_gnt2", q_at(gnt_log, 2), 32'h108);
    chk("seq_wr0",  q_at(wr_log, 0),  32'h100);
    chk("seq_wr1",  q_at(wr_log, 1),  32'h104);
    chk("seq_clr_n", 32'(clr_log.size()), 32'd1);
    chk("seq_clr_off", q_at(clr_log, 0), 32'd0);

    // unaligned boot, then redirect over two outstanding requests
    do_reset();
    boot_addr_i = 32'h202;
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    chk("boot_align", s_addr, 32'h200);
    chk("boot_off", q_at(clr_log, 0), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 0);
    wr_log.delete();
    cycle(1'b1, 1'b1, 32'h4006, 1'b1, 1'b0, 0);
    chk("redir_off", q_at(clr_log, 1), 32'd1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 100);
    chk("redir_gnt", q_at(gnt_log, 2), 32'h4004);
    chk("redir_wr0", q_at(wr_log, 0), 32'h4004);
    chk("redir_wr1", q_at(wr_log, 1), 32'h4008);

    // buffer full: credit stops at DEPTH, FIFO drains in order afterwards
    do_reset();
    boot_addr_i = 32'h0;
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 100);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 100);
    chk("full_gnts", 32'(gnt_log.size()), 32'd2);
    chk("full_nowr", 32'(wr_log.size()), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 100);
    chk("full_wr0", q_at(wr_log, 0), 32'h0);
    chk("full_wr1", q_at(wr_log, 1), 32'h4);
    chk("full_b2b", 32'((wr_cyc.size() > 1) ? wr_cyc[1] - wr_cyc[0] : 0), 32'd1);

    // redirect while a request waits for its grant
    do_reset();
    boot_addr_i = 32'h10;
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 100);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 100);
    cycle(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 100);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 100);
    chk("stale_hold", s_addr, 32'h10);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 100);
    chk("stale_gnt0", q_at(gnt_log, 0), 32'h10);
    chk("stale_gnt1", q_at(gnt_log, 1), 32'h80);
    chk("stale_wr0",  q_at(wr_log, 0),  32'h80);

    // halt mid-stream, drain, resume sequentially without a clear
    do_reset();
    boot_addr_i = 32'h300;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 100);
    chk("halt_busy", 32'(s_busy), 32'd0);
    chk("halt_gnts", 32'(gnt_log.size()), 32'd2);
    chk("halt_wr1",  q_at(wr_log, 1), 32'h304);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 100);
    chk("resume_gnt", q_at(gnt_log, 2), 32'h308);
    chk("resume_noclr", 32'(clr_log.size()), 32'd1);

    // randomized traffic with one asynchronous reset in the middle
    do_reset();
    boot_addr_i = $urandom;
    fe_r = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        do_reset();
        boot_addr_i = $urandom;
      end
      if ($urandom_range(99) < 3) fe_r = !fe_r;
      cycle(fe_r, ($urandom_range(99) < 5), $urandom,
            ($urandom_range(99) < 70), ($urandom_range(99) < 30), 60);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
